if_fetch_unit: RTL
==================

# if_fetch_unit

Instruction-fetch front end of the ARM pipeline. It owns the fetch PC, issues word reads to instruction memory over a req/ack handshake, and buffers returned words in a small prefetch FIFO. It presents `{pc, instruction, valid}` to the IF/ID pipeline register. It also redirects on taken branches and discards any in-flight fetch that a redirect makes stale.

## Interface
- `BIT_NUMBER`, 32: address and instruction width.
- `FIFO_DEPTH`, 2: prefetch entries; a power of two, at least 2.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `freeze`  in  1  hazard stall; the downstream register is not consuming this cycle.
- `branch_taken`  in  1  redirect request from EXE.
- `branch_address`  in  BIT_NUMBER  redirect target, word aligned.
- `imem_req`  out  1  read request.
- `imem_addr`  out  BIT_NUMBER  read address.
- `imem_ack`  in  1  read completes this cycle; `imem_rdata` is valid.
- `imem_rdata`  in  BIT_NUMBER  read data.
- `pc`  out  BIT_NUMBER  fetched address + 4.
- `instruction`  out  BIT_NUMBER  fetched word.
- `valid`  out  1  `pc`/`instruction` hold a real fetch.

## Operation
- States:
  - IDLE: entered on reset; lasts exactly one cycle, then goes to FETCH.
  - FETCH: normal fetching.
  - DISCARD: an in-flight read has been made stale and must be dropped.
- Fetch PC `fpc`:
  - Reset value 0.
  - `imem_addr` = `fpc` in FETCH and DISCARD; `imem_addr` = 0 in IDLE.
- `imem_req`:
  - In FETCH, asserted when FIFO count < `FIFO_DEPTH`.
  - In DISCARD, always asserted.
  - In IDLE, low.
- Handshake:
  - A transfer happens on any cycle with `imem_req && imem_ack`; a zero-wait ack in the request cycle is legal.
  - Once raised, `imem_req` and `imem_addr` stay stable until the transfer. The FIFO count cannot rise while a read is pending, so this holds by construction.
- Transfer in FETCH with no branch:
  - Push `{fpc + 4, imem_rdata}`.
  - `fpc` <= `fpc + 4`, wrapping modulo 2^BIT_NUMBER.
- Transfer in DISCARD:
  - Drop the data.
  - `fpc` <= `redirect_pc`; go to FETCH.
- Pop: when `!freeze` and the FIFO is not empty. Push and pop in the same cycle are both performed.
- Output, combinational from the FIFO head:
  - FIFO not empty: `pc`/`instruction` show the head entry and `valid` = 1.
  - FIFO empty: `pc` = 0, `instruction` = 32'hF000_0000 (NV-condition NOP), `valid` = 0.
- `branch_taken` overrides `freeze` and any pop. On a cycle with `branch_taken` = 1:
  - The FIFO is cleared.
  - FETCH, no request pending or transfer this cycle: `fpc` <= `branch_address`; any transfer data is dropped; stay in FETCH.
  - FETCH, request pending without ack: `redirect_pc` <= `branch_address`; go to DISCARD.
  - DISCARD without ack: `redirect_pc` <= `branch_address` (the latest target wins).
  - DISCARD with ack: `fpc` <= `branch_address`; go to FETCH.
  - IDLE: `fpc` <= `branch_address`.

## Timing
- Reset values:
  - `imem_req` = 0, `imem_addr` = 0.
  - `pc` = 0, `instruction` = 32'hF000_0000, `valid` = 0.
  - FIFO empty, state IDLE, `fpc` = 0, `redirect_pc` = 0.
- Cycle numbering is from the first edge after `rst_n` rises. Cycle 0 is IDLE; cycle 1 raises `imem_req` to address 0.
- Fetch-to-output latency:
  - A word acked in cycle n is on the outputs with `valid` = 1 in cycle n+1.
  - Zero-wait memory with no freeze sustains one instruction per cycle.
- A branch in cycle n:
  - `valid` = 0 in cycle n+1.
  - With no read pending, the target is requested in cycle n+1.
- FIFO full and frozen: `imem_req` is held low, and `fpc` is unchanged until a pop.
- Reset asserted mid-transfer: all state returns to reset values immediately. The memory must tolerate an abandoned request.

## Structure
- Shared package `arm_pkg`:
  - `NOP_INSTR` = 32'hF000_0000, shared with the IF/ID register's flush value.
  - Fetch state enum {IDLE, FETCH, DISCARD}.
- Sub-module `fetch_fifo`:
  - Parameterised width and depth.
  - Ports: push, pop, clear, data, full, empty, count.
  - Clear has priority over push and pop.
  - Asynchronous active-low reset.

## Test plan
- Zero-wait memory (ack tied high), no freeze, `rdata` = address:
  - `valid` rises in cycle 2.
  - Outputs then give pc = 4, 8, 12… with instruction = 0, 4, 8… on consecutive cycles.
- `freeze` held 4 cycles with zero-wait memory:
  - FIFO fills to 2 and `imem_req` drops.
  - Outputs hold pc = 4 / instruction = 0.
  - On release, the sequence resumes without loss.
- Memory acking 3 cycles after req:
  - `imem_addr` is stable throughout.
  - Outputs appear every 4 cycles.
- Branch to 0x100 while a read of 0x8 is pending:
  - The 0x8 data is dropped.
  - The next request is 0x100, and the next valid output is pc = 0x104.
- Branch together with freeze and a full FIFO:
  - The FIFO clears and `valid` = 0 next cycle.
  - The fetch restarts at the target.
- `rst_n` pulsed low mid-stream:
  - All outputs take reset values immediately.
  - The IDLE cycle, then a fetch from 0, follows release.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: the NV-condition NOP used as the empty/flush
// instruction and the fetch-unit state encoding.
package arm_pkg;

    localparam logic [31:0] NOP_INSTR = 32'hF000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO for the fetch unit. Clear wins over push and pop;
// the head entry is visible combinationally on rd_data.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, reads instruction memory,
// buffers words in a prefetch FIFO and redirects on taken branches.
module if_fetch_unit
    import arm_pkg::*;
#(
    parameter int BIT_NUMBER = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [BIT_NUMBER-1:0] branch_address,
    output logic                  imem_req,
    output logic [BIT_NUMBER-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [BIT_NUMBER-1:0] imem_rdata,
    output logic [BIT_NUMBER-1:0] pc,
    output logic [BIT_NUMBER-1:0] instruction,
    output logic                  valid
);

    localparam int EW = 2 * BIT_NUMBER;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BIT_NUMBER-1:0] WORD_BYTES = BIT_NUMBER'(4);

    fetch_state_t          state, state_nxt;
    logic [BIT_NUMBER-1:0] fpc, fpc_nxt;
    logic [BIT_NUMBER-1:0] redirect_pc, redirect_nxt;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [EW-1:0] fifo_head;
    logic          fetch_req;

    // Handshake: a read transfers on any cycle with imem_req && imem_ack (the ack
    // may arrive in the request cycle). Once raised, imem_req/imem_addr hold until
    // that transfer; the FIFO count cannot rise while a read is pending.
    assign fetch_req = !fifo_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fpc         <= '0;
            redirect_pc <= '0;
        end else begin
            state       <= state_nxt;
            fpc         <= fpc_nxt;
            redirect_pc <= redirect_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fpc_nxt      = fpc;
        redirect_nxt = redirect_pc;
        imem_req     = 1'b0;
        imem_addr    = fpc;
        fifo_push    = 1'b0;
        case (state)
            IDLE: begin
                imem_addr = '0;
                state_nxt = FETCH;
                if (branch_taken) fpc_nxt = branch_address;
            end
            FETCH: begin
                imem_req = fetch_req;
                if (branch_taken) begin
                    // A read already on the bus cannot be withdrawn, so drop it later.
                    if (fetch_req && !imem_ack) begin
                        redirect_nxt = branch_address;
                        state_nxt    = DISCARD;
                    end else begin
                        fpc_nxt = branch_address;
                    end
                end else if (fetch_req && imem_ack) begin
                    fifo_push = 1'b1;
                    fpc_nxt   = fpc + WORD_BYTES;
                end
            end
            DISCARD: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_nxt = FETCH;
                    fpc_nxt   = branch_taken ? branch_address : redirect_pc;
                end else if (branch_taken) begin
                    redirect_nxt = branch_address;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fifo_pop = !branch_taken && !freeze && !fifo_empty;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .clear   (branch_taken),
        .wr_data ({fpc + WORD_BYTES, imem_rdata}),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign valid       = !fifo_empty;
    assign pc          = valid ? fifo_head[EW-1:BIT_NUMBER] : '0;
    assign instruction = valid ? fifo_head[BIT_NUMBER-1:0] : BIT_NUMBER'(NOP_INSTR);

endmodule
